// File: rtl/mem_subsys_ctrl.sv
// mem_subsys_ctrl: dual-port byte-lane RAM for the RISC-V core.
// Port A is a read-only fetch port. Port B does byte/half/word loads and
// stores with sign/zero extension and misalignment faults. Read latency is
// 1 or 2 cycles. An optional sequencer zeroes the whole array after reset.
module mem_subsys_ctrl #(
  parameter int unsigned DEPTH_WORDS    = 32768,
  parameter int unsigned READ_LAT       = 1,
  parameter bit          CLEAR_ON_RESET = 1'b0,
  parameter logic [1:0]  MEM_DISABLE    = 2'b00,
  parameter logic [1:0]  MEM_READ_SEXT  = 2'b01,
  parameter logic [1:0]  MEM_READ_ZEXT  = 2'b10,
  parameter logic [1:0]  MEM_WRITE      = 2'b11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req_i,
  input  logic [31:0] a_addr_i,
  output logic [31:0] a_rdata_o,
  output logic        a_valid_o,
  input  logic [1:0]  b_op_i,
  input  logic [1:0]  b_size_i,
  input  logic [31:0] b_addr_i,
  input  logic [31:0] b_wdata_i,
  output logic [31:0] b_rdata_o,
  output logic        b_valid_o,
  output logic        b_misalign_o,
  output logic        ready_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
  logic             run;
  logic             clr_we;

  // Pick the byte lane of a read word and widen it to 32 bits.
  function automatic logic [31:0] lane_extend(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [1:0]  size,
                                              input logic        sext);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {off, 3'b000};
    case (size)
      2'b00:   res = sext ? {{24{sh[7]}}, sh[7:0]}   : {24'h0, sh[7:0]};
      2'b01:   res = sext ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

  // Hold the sequencer state; reset restarts the clear at word 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Walk the clear counter over every word, then open the ports.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    run       = 1'b0;
    clr_we    = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we    = ~reset;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == IDX_W'(DEPTH_WORDS - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: run = 1'b1;
      default: state_d = ST_RUN;
    endcase
  end

  // Requests are only taken while running and out of reset.
  assign ready_o = run & ~reset;

  // Request decode for port B.
  logic [IDX_W-1:0] a_idx, b_idx, wr_idx;
  logic [1:0]       b_off;
  logic             b_is_load, b_is_store, b_active, b_mis;
  logic             a_rd_en, b_rd_en, b_st_en, b_fire;
  logic [3:0]       st_be, wr_be;
  logic [31:0]      wr_data;
  logic [31:0]      rd_a, rd_b;
  logic             unused_addr_bits;

  assign a_idx      = a_addr_i[IDX_W+1:2];
  assign b_idx      = b_addr_i[IDX_W+1:2];
  assign b_off      = b_addr_i[1:0];
  assign b_active   = (b_op_i != MEM_DISABLE);
  assign b_is_load  = (b_op_i == MEM_READ_SEXT) || (b_op_i == MEM_READ_ZEXT);
  assign b_is_store = (b_op_i == MEM_WRITE);
  // Half needs bit 0 clear; word (and the reserved size) needs both clear.
  assign b_mis      = ((b_size_i == 2'b01) && b_off[0]) ||
                      (b_size_i[1] && (b_off != 2'b00));
  assign a_rd_en    = ready_o & a_req_i;
  assign b_rd_en    = ready_o & b_is_load & ~b_mis;
  assign b_st_en    = ready_o & b_is_store & ~b_mis;
  assign b_fire     = ready_o & b_active & (b_is_load | b_mis);

  // Upper address bits wrap modulo depth; the fetch offset is meaningless.
  assign unused_addr_bits = ^{a_addr_i[31:IDX_W+2], a_addr_i[1:0],
                              b_addr_i[31:IDX_W+2]};

  // Store byte enables for the addressed lanes.
  always_comb begin
    st_be = 4'b0000;
    case (b_size_i)
      2'b00:   st_be = 4'b0001 << b_off;
      2'b01:   st_be = 4'b0011 << b_off;
      default: st_be = 4'b1111;
    endcase
  end

  // The clear sequencer borrows the port B write path.
  assign wr_idx  = clr_we ? clr_cnt_q : b_idx;
  assign wr_be   = clr_we ? 4'b1111 : (b_st_en ? st_be : 4'b0000);
  assign wr_data = clr_we ? 32'h0 : (b_wdata_i << {b_off, 3'b000});

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH_WORDS];
    logic [7:0] a_byte_q;
    logic [7:0] b_byte_q;

    // Byte-lane write from port B (or the clear sequencer).
    always_ff @(posedge clk) begin
      if (wr_be[gi]) begin
        lane_mem[wr_idx] <= wr_data[8*gi +: 8];
      end
    end

    // Fetch read; sees the old word when B stores to it the same cycle.
    always_ff @(posedge clk) begin
      if (reset) begin
        a_byte_q <= '0;
      end else if (a_rd_en) begin
        a_byte_q <= lane_mem[a_idx];
      end
    end

    // Load read; holds its value between loads.
    always_ff @(posedge clk) begin
      if (reset) begin
        b_byte_q <= '0;
      end else if (b_rd_en) begin
        b_byte_q <= lane_mem[b_idx];
      end
    end

    assign rd_a[8*gi +: 8] = a_byte_q;
    assign rd_b[8*gi +: 8] = b_byte_q;
  end

  // First pipeline stage: valids and the load format travelling with the RAM read.
  logic       a_v1_q, b_v1_q, b_mis1_q, b_sext1_q;
  logic [1:0] b_off1_q, b_size1_q;

  // Capture the request shape alongside the RAM access.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_v1_q    <= 1'b0;
      b_v1_q    <= 1'b0;
      b_mis1_q  <= 1'b0;
      b_sext1_q <= 1'b0;
      b_off1_q  <= '0;
      b_size1_q <= '0;
    end else begin
      a_v1_q <= a_rd_en;
      b_v1_q <= b_fire;
      if (b_fire) begin
        b_mis1_q  <= b_mis;
        b_sext1_q <= (b_op_i == MEM_READ_SEXT);
        b_off1_q  <= b_off;
        b_size1_q <= b_size_i;
      end
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    logic        a_v2_q, b_v2_q, b_mis2_q, b_sext2_q;
    logic [31:0] a_d2_q, b_d2_q;
    logic [1:0]  b_off2_q, b_size2_q;

    // Extra output stage; data only moves when a result is present.
    always_ff @(posedge clk) begin
      if (reset) begin
        a_v2_q    <= 1'b0;
        a_d2_q    <= '0;
        b_v2_q    <= 1'b0;
        b_d2_q    <= '0;
        b_mis2_q  <= 1'b0;
        b_sext2_q <= 1'b0;
        b_off2_q  <= '0;
        b_size2_q <= '0;
      end else begin
        a_v2_q <= a_v1_q;
        b_v2_q <= b_v1_q;
        if (a_v1_q) begin
          a_d2_q <= rd_a;
        end
        if (b_v1_q) begin
          b_d2_q    <= rd_b;
          b_mis2_q  <= b_mis1_q;
          b_sext2_q <= b_sext1_q;
          b_off2_q  <= b_off1_q;
          b_size2_q <= b_size1_q;
        end
      end
    end

    assign a_valid_o    = a_v2_q;
    assign a_rdata_o    = a_d2_q;
    assign b_valid_o    = b_v2_q;
    assign b_misalign_o = b_mis2_q;
    assign b_rdata_o    = b_mis2_q ? 32'h0 :
                          lane_extend(b_d2_q, b_off2_q, b_size2_q, b_sext2_q);
  end else begin : g_lat1
    assign a_valid_o    = a_v1_q;
    assign a_rdata_o    = rd_a;
    assign b_valid_o    = b_v1_q;
    assign b_misalign_o = b_mis1_q;
    assign b_rdata_o    = b_mis1_q ? 32'h0 :
                          lane_extend(rd_b, b_off1_q, b_size1_q, b_sext1_q);
  end

endmodule

// File: tb/tb_mem_subsys_ctrl.sv
// Bench for mem_subsys_ctrl: two instances share one stimulus stream.
// dut0: 16 words, latency 1, clear on reset. dut1: 16 words, latency 2, no clear.
// A byte-array model predicts every output each cycle; directed literals pin it.
module tb_mem_subsys_ctrl;

  localparam int DW = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_req;
  logic [31:0] a_addr;
  logic [1:0]  b_op, b_size;
  logic [31:0] b_addr, b_wdata;
  logic [31:0] a_rdata [2];
  logic [31:0] b_rdata [2];
  logic        a_valid [2];
  logic        b_valid [2];
  logic        b_mis   [2];
  logic        ready   [2];

  always #5 clk = ~clk;

  mem_subsys_ctrl #(.DEPTH_WORDS(16), .READ_LAT(1), .CLEAR_ON_RESET(1'b1)) dut0 (
    .clk(clk), .reset(reset),
    .a_req_i(a_req), .a_addr_i(a_addr), .a_rdata_o(a_rdata[0]), .a_valid_o(a_valid[0]),
    .b_op_i(b_op), .b_size_i(b_size), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .b_rdata_o(b_rdata[0]), .b_valid_o(b_valid[0]), .b_misalign_o(b_mis[0]),
    .ready_o(ready[0]));

  mem_subsys_ctrl #(.DEPTH_WORDS(16), .READ_LAT(2), .CLEAR_ON_RESET(1'b0)) dut1 (
    .clk(clk), .reset(reset),
    .a_req_i(a_req), .a_addr_i(a_addr), .a_rdata_o(a_rdata[1]), .a_valid_o(a_valid[1]),
    .b_op_i(b_op), .b_size_i(b_size), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .b_rdata_o(b_rdata[1]), .b_valid_o(b_valid[1]), .b_misalign_o(b_mis[1]),
    .ready_o(ready[1]));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int i, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: actual=%h required=%h", name, i, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        av;
    logic [31:0] ad;
    logic        bv;
    logic        bm;
    logic [31:0] bd;
  } res_t;

  int         lat [2] = '{1, 2};
  bit         clr [2] = '{1'b1, 1'b0};
  logic [7:0] mem_m [2][64];
  int         clear_left [2];
  res_t       pipe [2];
  res_t       cur  [2];
  bit         started = 1'b0;

  function automatic logic [31:0] model_word(input int i, input int w);
    return {mem_m[i][w*4+3], mem_m[i][w*4+2], mem_m[i][w*4+1], mem_m[i][w*4]};
  endfunction

  task automatic apply(input int i, input res_t r);
    cur[i].av = r.av;
    cur[i].bv = r.bv;
    if (r.av) cur[i].ad = r.ad;
    if (r.bv) begin
      cur[i].bd = r.bd;
      cur[i].bm = r.bm;
    end
  endtask

  task automatic model_step();
    res_t        r;
    bit          acc;
    int          off, n, base;
    logic [31:0] v;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        clear_left[i] = clr[i] ? DW : 0;
        pipe[i] = '0;
        cur[i]  = '0;
      end else begin
        r   = '0;
        acc = (clear_left[i] == 0);
        if (clear_left[i] > 0) begin
          clear_left[i]--;
          if (clear_left[i] == 0)
            for (int k = 0; k < 64; k++) mem_m[i][k] = 8'h00;
        end
        if (acc) begin
          if (a_req) begin
            r.av = 1'b1;
            r.ad = model_word(i, int'(a_addr[5:2]));
          end
          if (b_op != 2'b00) begin
            off  = int'(b_addr[1:0]);
            n    = (b_size == 2'b00) ? 1 : (b_size == 2'b01) ? 2 : 4;
            base = int'(b_addr[5:2]) * 4;
            if ((off % n) != 0) begin
              r.bv = 1'b1;
              r.bm = 1'b1;
              r.bd = 32'h0;
            end else if (b_op == 2'b11) begin
              for (int k = 0; k < n; k++) mem_m[i][base+off+k] = b_wdata[8*k +: 8];
            end else begin
              v = 32'h0;
              for (int k = 0; k < n; k++) v[8*k +: 8] = mem_m[i][base+off+k];
              if (b_op == 2'b01 && n < 4 && v[8*n-1])
                for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
              r.bv = 1'b1;
              r.bd = v;
            end
          end
        end
        if (lat[i] == 1) begin
          apply(i, r);
        end else begin
          apply(i, pipe[i]);
          pipe[i] = r;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
    started = 1'b1;
  end

  // Compare every output of both instances against the model each cycle.
  initial forever begin
    @(negedge clk);
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        chk("ready",      i, 32'(ready[i]),   32'(!reset && clear_left[i] == 0));
        chk("a_valid",    i, 32'(a_valid[i]), 32'(cur[i].av));
        chk("a_rdata",    i, a_rdata[i],      cur[i].ad);
        chk("b_valid",    i, 32'(b_valid[i]), 32'(cur[i].bv));
        chk("b_misalign", i, 32'(b_mis[i]),   32'(cur[i].bm));
        chk("b_rdata",    i, b_rdata[i],      cur[i].bd);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic        s_av [2];
  logic        s_bv [2];
  logic        s_bm [2];
  logic [31:0] s_ad [2];
  logic [31:0] s_bd [2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_req = 1'b0;
    b_op  = 2'b00;
  endtask

  // One request cycle, then sample dut0 one cycle later and dut1 two cycles later.
  task automatic xact(input logic ar, input logic [31:0] aa, input logic [1:0] op,
                      input logic [1:0] sz, input logic [31:0] ba, input logic [31:0] wd);
    a_req = ar; a_addr = aa; b_op = op; b_size = sz; b_addr = ba; b_wdata = wd;
    $display("xact a_req=%0d a_addr=%h b_op=%0d b_size=%0d b_addr=%h b_wdata=%h",
             ar, aa, op, sz, ba, wd);
    tick();
    idle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      s_av[i] = a_valid[i]; s_ad[i] = a_rdata[i];
      s_bv[i] = b_valid[i]; s_bd[i] = b_rdata[i]; s_bm[i] = b_mis[i];
      tick();
    end
  endtask

  task automatic lit_a(input string name, input logic [31:0] exp);
    for (int i = 0; i < 2; i++) begin
      chk({name, "_av"}, i, 32'(s_av[i]), 32'd1);
      chk({name, "_ad"}, i, s_ad[i], exp);
    end
  endtask

  task automatic lit_b(input string name, input logic [31:0] exp, input logic mis);
    for (int i = 0; i < 2; i++) begin
      chk({name, "_bv"}, i, 32'(s_bv[i]), 32'd1);
      chk({name, "_bm"}, i, 32'(s_bm[i]), 32'(mis));
      chk({name, "_bd"}, i, s_bd[i], exp);
    end
  endtask

  int          n;
  logic        v0 [5];
  logic        v1 [5];
  logic [31:0] d0 [5];
  logic [31:0] d1 [5];
  logic [31:0] w5 [3];

  initial begin
    idle();
    a_addr = '0; b_size = '0; b_addr = '0; b_wdata = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // T1: dut0 clears for 16 cycles; meanwhile dut1 gets zeroed by stores.
    n = 0;
    for (int k = 0; k < 16; k++) begin
      b_op = 2'b11; b_size = 2'b10; b_addr = 32'(4 * k); b_wdata = 32'h0;
      $display("xact init store word addr=%h", b_addr);
      @(negedge clk);
      if (!ready[0]) n++;
      tick();
    end
    idle();
    @(negedge clk);
    chk("t1_ready_after_clear", 0, 32'(ready[0]), 32'd1);
    chk("t1_clear_cycles", 0, 32'(n), 32'd16);
    tick();

    // T1: reset again, then reassert at clear cycle 7 -> full restart.
    reset = 1'b1; tick(); reset = 1'b0;
    repeat (7) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    $display("xact reset reasserted at clear cycle 7");
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready[0]) break;
      n++;
      tick();
    end
    chk("t1_restart_cycles", 0, 32'(n), 32'd16);
    tick();
    xact(1'b1, 32'h14, 2'b10, 2'b10, 32'h14, 32'h0);
    lit_a("t1_a_word5", 32'h0);
    lit_b("t1_b_word5", 32'h0, 1'b0);

    // T2: extension of byte/half lanes.
    xact(1'b0, 32'h0, 2'b11, 2'b10, 32'h40, 32'hDEADBEEF);
    xact(1'b0, 32'h0, 2'b10, 2'b00, 32'h43, 32'h0);
    lit_b("t2_zext_byte", 32'h000000DE, 1'b0);
    xact(1'b0, 32'h0, 2'b01, 2'b00, 32'h43, 32'h0);
    lit_b("t2_sext_byte", 32'hFFFFFFDE, 1'b0);
    xact(1'b0, 32'h0, 2'b01, 2'b01, 32'h40, 32'h0);
    lit_b("t2_sext_half", 32'hFFFFBEEF, 1'b0);

    // T3: byte store into lane 1.
    xact(1'b0, 32'h0, 2'b11, 2'b00, 32'h41, 32'h00000012);
    xact(1'b0, 32'h0, 2'b10, 2'b10, 32'h40, 32'h0);
    lit_b("t3_word", 32'hDEAD12EF, 1'b0);

    // T4: misaligned store and load fault without touching memory.
    xact(1'b0, 32'h0, 2'b11, 2'b10, 32'h42, 32'h01234567);
    lit_b("t4_store_fault", 32'h0, 1'b1);
    xact(1'b0, 32'h0, 2'b10, 2'b10, 32'h40, 32'h0);
    lit_b("t4_word_kept", 32'hDEAD12EF, 1'b0);
    xact(1'b0, 32'h0, 2'b01, 2'b01, 32'h41, 32'h0);
    lit_b("t4_half_fault", 32'h0, 1'b1);

    // T6: address wrap modulo 16 words.
    xact(1'b0, 32'h0, 2'b11, 2'b10, 32'h44, 32'hCAFEF00D);
    xact(1'b1, 32'h44, 2'b10, 2'b10, 32'h04, 32'h0);
    lit_a("t6_wrap_a", 32'hCAFEF00D);
    lit_b("t6_wrap_b", 32'hCAFEF00D, 1'b0);

    // T5: back-to-back fetches; dut0 answers at 1..3, dut1 at 2..4.
    xact(1'b0, 32'h0, 2'b11, 2'b10, 32'h08, 32'h11223344);
    w5[0] = 32'hDEAD12EF; w5[1] = 32'hCAFEF00D; w5[2] = 32'h11223344;
    for (int c = 0; c < 5; c++) begin
      a_req = (c < 3); a_addr = 32'(4 * c); b_op = 2'b00;
      if (c < 3) $display("xact fetch addr=%h", a_addr);
      @(negedge clk);
      v0[c] = a_valid[0]; d0[c] = a_rdata[0];
      v1[c] = a_valid[1]; d1[c] = a_rdata[1];
      tick();
    end
    idle();
    for (int c = 0; c < 5; c++) begin
      chk("t5_av", 0, 32'(v0[c]), 32'(c >= 1 && c <= 3));
      chk("t5_av", 1, 32'(v1[c]), 32'(c >= 2 && c <= 4));
      if (c >= 1 && c <= 3) chk("t5_ad", 0, d0[c], w5[c-1]);
      if (c >= 2) chk("t5_ad", 1, d1[c], w5[c-2]);
    end

    // T5: same-cycle fetch and store to one word -> fetch sees old data.
    xact(1'b1, 32'h08, 2'b11, 2'b10, 32'h08, 32'h55667788);
    lit_a("t5_read_first", 32'h11223344);
    xact(1'b1, 32'h08, 2'b10, 2'b10, 32'h08, 32'h0);
    lit_a("t5_new_a", 32'h55667788);
    lit_b("t5_new_b", 32'h55667788, 1'b0);

    // Store then load of the same word on consecutive cycles.
    b_op = 2'b11; b_size = 2'b01; b_addr = 32'h0A; b_wdata = 32'h0000ABCD;
    $display("xact store half addr=%h data=%h", b_addr, b_wdata);
    tick();
    xact(1'b0, 32'h0, 2'b01, 2'b01, 32'h0A, 32'h0);
    lit_b("store_then_load", 32'hFFFFABCD, 1'b0);

    // Mixed directed sweep of ops, sizes, offsets and fetches.
    for (int k = 0; k < 32; k++) begin
      a_req   = k[0];
      a_addr  = 32'(5 * k);
      b_op    = 2'(k % 4);
      b_size  = 2'((k / 4) % 4);
      b_addr  = 32'(32'h100 + 5 * k);
      b_wdata = 32'h9E3779B9 * 32'(k + 1);
      $display("xact sweep a_req=%0d a_addr=%h b_op=%0d b_size=%0d b_addr=%h b_wdata=%h",
               a_req, a_addr, b_op, b_size, b_addr, b_wdata);
      tick();
    end
    idle();
    repeat (3) tick();

    // Reset with reads in flight: they must be dropped.
    a_req = 1'b1; a_addr = 32'h08; b_op = 2'b10; b_size = 2'b10; b_addr = 32'h04;
    $display("xact fetch+load then reset");
    tick();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (20) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
